// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen -- program-counter generator at the head of the fetch stage.
//
// Presents the fetch address to the IFU over a valid/ready handshake. The next
// PC is chosen with priority trap > redirect > sequential (pc + STEP). A trap or
// redirect target with any of its low ALIGN_BITS bits set parks the block in
// FAULT. Only an aligned trap target brings the block back to RUN.
//
// Ports
//   clk             clock, all state updates on posedge
//   rst             asynchronous active-low reset
//   stall           suppresses pc_valid and therefore sequential advance
//   redirect_valid  branch/jump redirect pulse, target on redirect_pc
//   trap_valid      trap/mret redirect pulse, target on trap_pc; beats redirect
//   pc_ready        IFU accepts the presented address
//   pc_valid        pc is a valid fetch address (RUN and not stalled)
//   pc              current fetch address
//   pc_misaligned   block is in FAULT because of a misaligned target
//   fetch_cnt       number of completed handshakes, wraps
// -----------------------------------------------------------------------------
module pc_gen #(
  parameter int unsigned                  DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]        RESET_VEC  = 32'h8000_0000,
  parameter int unsigned                  STEP       = 4,
  parameter int unsigned                  ALIGN_BITS = 2,
  parameter int unsigned                  CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  trap_valid,
  input  logic [DATA_WIDTH-1:0] trap_pc,
  input  logic                  pc_ready,
  output logic                  pc_valid,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  pc_misaligned,
  output logic [CNT_WIDTH-1:0]  fetch_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_e;

  // Low-bit mask of the alignment check; all zeros when ALIGN_BITS == 0, which
  // turns the check off without a zero-width slice.
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK =
    DATA_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   pc_q;
  logic                    misaligned_q;
  logic [CNT_WIDTH-1:0]    fetch_cnt_q;

  logic                    fire;
  logic                    jump_d;       // trap or redirect requested this edge
  logic [DATA_WIDTH-1:0]   jump_pc_d;    // selected trap/redirect target
  logic                    jump_bad_d;   // selected target is misaligned
  logic                    trap_bad_d;   // trap target is misaligned

  assign pc_valid      = (state_q == RUN) & ~stall;
  assign fire          = pc_valid & pc_ready;
  assign pc            = pc_q;
  assign pc_misaligned = misaligned_q;
  assign fetch_cnt     = fetch_cnt_q;

  // Target selection: trap wins over redirect.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the block leaves it unassigned, which would infer a latch.
    jump_d    = 1'b0;
    jump_pc_d = pc_q;
    if (trap_valid) begin
      jump_d    = 1'b1;
      jump_pc_d = trap_pc;
    end else if (redirect_valid) begin
      jump_d    = 1'b1;
      jump_pc_d = redirect_pc;
    end
    jump_bad_d = |(jump_pc_d & ALIGN_MASK);
    trap_bad_d = |(trap_pc & ALIGN_MASK);
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VEC;
      misaligned_q <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      case (state_q)
        // One settling cycle after reset; redirects are ignored here.
        BOOT: state_q <= RUN;

        RUN: begin
          // A fire coinciding with a jump still counts: the old pc was taken.
          if (fire) fetch_cnt_q <= fetch_cnt_q + CNT_WIDTH'(1);
          if (jump_d) begin
            pc_q <= jump_pc_d;
            if (jump_bad_d) begin
              state_q      <= FAULT;
              misaligned_q <= 1'b1;
            end
          end else if (fire) begin
            pc_q <= pc_q + DATA_WIDTH'(STEP);
          end
        end

        // Only a trap leaves FAULT, and only with an aligned target.
        FAULT: begin
          if (trap_valid) begin
            pc_q <= trap_pc;
            if (!trap_bad_d) begin
              state_q      <= RUN;
              misaligned_q <= 1'b0;
            end
          end
        end

        default: state_q <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen -- self-checking bench for pc_gen.
// Directed walk through boot, backpressure, priority, fault, wrap and async
// reset, followed by randomized traffic. A second instance with a 4-bit fetch
// counter shares all inputs to exercise counter wrap.
// -----------------------------------------------------------------------------
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_pc = '0;
  logic        pc_ready = 1'b0;

  logic        pc_valid, pc_misaligned;
  logic [31:0] pc, fetch_cnt;
  logic        pc_valid4, pc_misaligned4;
  logic [31:0] pc4;
  logic [3:0]  fetch_cnt4;

  always #5 clk = ~clk;

  pc_gen u_dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .pc_ready(pc_ready),
    .pc_valid(pc_valid), .pc(pc), .pc_misaligned(pc_misaligned),
    .fetch_cnt(fetch_cnt)
  );

  pc_gen #(.CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .pc_ready(pc_ready),
    .pc_valid(pc_valid4), .pc(pc4), .pc_misaligned(pc_misaligned4),
    .fetch_cnt(fetch_cnt4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode, address, fetch count and fault flag.
  typedef enum {M_BOOT, M_RUN, M_FAULT} mode_e;
  mode_e       m_mode = M_BOOT;
  bit [31:0]   m_pc   = 32'h8000_0000;
  longint      m_cnt  = 0;
  bit          m_mis  = 1'b0;

  function automatic bit aligned(input bit [31:0] a);
    return (a % 4) == 0;
  endfunction

  task automatic model_reset();
    m_mode = M_BOOT;
    m_pc   = 32'h8000_0000;
    m_cnt  = 0;
    m_mis  = 1'b0;
  endtask

  task automatic model_edge();
    bit take;
    take = (m_mode == M_RUN) && !stall && pc_ready;
    case (m_mode)
      M_BOOT: m_mode = M_RUN;
      M_RUN: begin
        if (take) m_cnt = m_cnt + 1;
        if (trap_valid || redirect_valid) begin
          m_pc = trap_valid ? trap_pc : redirect_pc;
          if (!aligned(m_pc)) begin
            m_mode = M_FAULT;
            m_mis  = 1'b1;
          end
        end else if (take) begin
          m_pc = m_pc + 32'd4;
        end
      end
      M_FAULT: begin
        if (trap_valid) begin
          m_pc = trap_pc;
          if (aligned(trap_pc)) begin
            m_mode = M_RUN;
            m_mis  = 1'b0;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all(input string where);
    check({where, ".pc"},    64'(pc),            64'(m_pc));
    check({where, ".valid"}, 64'(pc_valid),      64'((m_mode == M_RUN) && !stall));
    check({where, ".mis"},   64'(pc_misaligned), 64'(m_mis));
    check({where, ".cnt"},   64'(fetch_cnt),     64'(m_cnt % 64'h1_0000_0000));
    check({where, ".cnt4"},  64'(fetch_cnt4),    64'(m_cnt % 16));
    check({where, ".pc4"},   64'(pc4),           64'(m_pc));
  endtask

  // Drive one cycle of inputs (at posedge+1), let the edge happen, compare.
  task automatic cyc(input bit s, input bit r, input bit rv, input bit [31:0] rpc,
                     input bit tv, input bit [31:0] tpc, input string where);
    stall = s; pc_ready = r;
    redirect_valid = rv; redirect_pc = rpc;
    trap_valid = tv; trap_pc = tpc;
    model_edge();
    @(posedge clk);
    #1;
    compare_all(where);
  endtask

  task automatic fetch(input string where);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, where);
  endtask

  // Assert reset between edges, check immediately, hold across one edge.
  task automatic async_reset(input string where);
    #2;
    rst = 1'b0;
    redirect_valid = 1'b0;
    trap_valid = 1'b0;
    #1;
    model_reset();
    check({where, ".rst_pc"},    64'(pc),            64'h8000_0000);
    check({where, ".rst_valid"}, 64'(pc_valid),      64'h0);
    check({where, ".rst_cnt"},   64'(fetch_cnt),     64'h0);
    check({where, ".rst_mis"},   64'(pc_misaligned), 64'h0);
    @(posedge clk);
    #1;
    compare_all({where, ".held"});
    #2;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    // Reset held for three edges.
    repeat (3) @(posedge clk);
    #1;
    check("boot.pc",    64'(pc),            64'h8000_0000);
    check("boot.valid", 64'(pc_valid),      64'h0);
    check("boot.cnt",   64'(fetch_cnt),     64'h0);
    check("boot.mis",   64'(pc_misaligned), 64'h0);
    #2 rst = 1'b1;
    #1;

    // First edge after release: BOOT -> RUN, no fetch yet.
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, "boot1");
    check("boot1.valid", 64'(pc_valid), 64'h1);
    check("boot1.pc",    64'(pc),       64'h8000_0000);
    fetch("seq1");
    check("seq1.pc",  64'(pc),        64'h8000_0004);
    check("seq1.cnt", 64'(fetch_cnt), 64'd1);
    fetch("seq2");
    check("seq2.pc",  64'(pc),        64'h8000_0008);
    check("seq2.cnt", 64'(fetch_cnt), 64'd2);
    fetch("seq3");
    check("seq3.cnt", 64'(fetch_cnt), 64'd3);
    fetch("seq4");
    check("seq4.pc",  64'(pc),        64'h8000_0010);

    // Backpressure: address holds, count frozen.
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, "bp");
    check("bp.pc",  64'(pc),        64'h8000_0010);
    check("bp.cnt", 64'(fetch_cnt), 64'd4);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, "stall");
    check("stall.valid", 64'(pc_valid), 64'h0);
    check("stall.pc",    64'(pc),       64'h8000_0010);
    fetch("unstall");
    check("unstall.pc", 64'(pc), 64'h8000_0014);

    // Priority: trap over redirect over sequential, fire still counted.
    cyc(1'b0, 1'b0, 1'b1, 32'h8000_0020, 1'b0, 32'h0, "goto20");
    cyc(1'b0, 1'b1, 1'b1, 32'h8000_0200, 1'b1, 32'h8000_0100, "prio");
    check("prio.pc",  64'(pc),        64'h8000_0100);
    check("prio.cnt", 64'(fetch_cnt), 64'd6);
    cyc(1'b1, 1'b0, 1'b1, 32'h8000_0030, 1'b0, 32'h0, "rd_stall");
    check("rd_stall.pc",    64'(pc),       64'h8000_0030);
    check("rd_stall.valid", 64'(pc_valid), 64'h0);

    // Misalignment and FAULT recovery.
    cyc(1'b0, 1'b0, 1'b1, 32'h8000_0006, 1'b0, 32'h0, "mis");
    check("mis.pc",    64'(pc),            64'h8000_0006);
    check("mis.flag",  64'(pc_misaligned), 64'h1);
    check("mis.valid", 64'(pc_valid),      64'h0);
    cyc(1'b0, 1'b1, 1'b1, 32'h8000_0040, 1'b0, 32'h0, "flt_rd");
    check("flt_rd.pc",  64'(pc),        64'h8000_0006);
    check("flt_rd.cnt", 64'(fetch_cnt), 64'd6);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_0003, "flt_trap_bad");
    check("flt_trap_bad.pc",  64'(pc),            64'h8000_0003);
    check("flt_trap_bad.mis", 64'(pc_misaligned), 64'h1);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_0080, "flt_exit");
    check("flt_exit.pc",    64'(pc),            64'h8000_0080);
    check("flt_exit.valid", 64'(pc_valid),      64'h1);
    check("flt_exit.mis",   64'(pc_misaligned), 64'h0);

    // Address wrap.
    cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, "to_top");
    fetch("pc_wrap");
    check("pc_wrap.pc", 64'(pc), 64'h0);

    // Narrow counter wrap: advance to 15, then one more fetch.
    for (int i = 0; i < 16 && (m_cnt % 16) != 15; i++) fetch("to15");
    check("cnt4.at15", 64'(fetch_cnt4), 64'd15);
    fetch("cnt4wrap");
    check("cnt4.wrap", 64'(fetch_cnt4), 64'd0);

    // Async reset mid-run at a known address.
    cyc(1'b0, 1'b0, 1'b1, 32'h8000_0044, 1'b0, 32'h0, "at44");
    check("at44.pc", 64'(pc), 64'h8000_0044);
    async_reset("arst");

    // Randomized traffic with occasional resets, including from FAULT.
    for (int n = 0; n < 2000; n++) begin
      bit s, r, rv, tv;
      bit [31:0] rpc, tpc;
      s   = ($urandom_range(0, 3) == 0);
      r   = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 7) == 0);
      tv  = ($urandom_range(0, 15) == 0);
      rpc = $urandom & ~32'h3;
      tpc = $urandom & ~32'h3;
      if ($urandom_range(0, 4) == 0) rpc = rpc | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0) tpc = tpc | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF8;
      cyc(s, r, rv, rpc, tv, tpc, "rnd");
      if ($urandom_range(0, 299) == 0) async_reset("rnd_arst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
